// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 multi-cycle sequencer.
// Used by the sequencer, the instruction classifier and the difftest hooks.
package ysyx_220053_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'd0,
    HC_EBREAK  = 2'd1,
    HC_ILLEGAL = 2'd2,
    HC_TIMEOUT = 2'd3
  } halt_cause_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] NOP    = 32'h00000013;

  typedef struct packed {
    logic writer;
    logic load;
    logic store;
    logic ebreak;
    logic illegal;
  } insn_class_t;

endpackage

// File: rtl/ysyx_220053_seq_ctrl_insn_class.sv
// Combinational instruction classifier: maps an instruction word to its
// sequencing class (register writer, load, store, ebreak, illegal).
module ysyx_220053_insn_class
  import ysyx_220053_pkg::*;
(
  input  logic [31:0] ir_i,
  output insn_class_t cls_o
);

  always_comb begin
    cls_o = '0;
    case (ir_i[6:0])
      OP_OP, OP_IMM, OP_IMM32, OP_OP32,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: cls_o.writer = 1'b1;
      OP_LOAD:   cls_o.load  = 1'b1;
      OP_STORE:  cls_o.store = 1'b1;
      OP_BRANCH: ;
      // Only the exact ebreak encoding is legal among SYSTEM instructions.
      OP_SYSTEM: begin
        if (ir_i == EBREAK) cls_o.ebreak  = 1'b1;
        else                cls_o.illegal = 1'b1;
      end
      default:   cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_220053_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, write strobes, sticky halt, bus timeout and perf counters.
module ysyx_220053_seq_ctrl
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        rf_wen,
  output logic        halt,
  output logic [1:0]  halt_cause,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  halt_cause_e cause_q, cause_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [63:0] cyc_q, instret_q;
  insn_class_t cls;

  ysyx_220053_insn_class u_insn_class (
    .ir_i  (ir_q),
    .cls_o (cls)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (tcnt_q == TLAST) begin
          state_d = S_HALT;
          cause_d = HC_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_DECODE: begin
        if (cls.ebreak) begin
          state_d = S_HALT;
          cause_d = HC_EBREAK;
        end else if (cls.illegal) begin
          state_d = S_HALT;
          cause_d = HC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = (cls.load || cls.store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (tcnt_q == TLAST) begin
          state_d = S_HALT;
          cause_d = HC_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Every state entry starts a fresh wait window.
    if (state_d != state_q) tcnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= NOP;
      cause_q   <= HC_NONE;
      tcnt_q    <= '0;
      cyc_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cause_q <= cause_d;
      tcnt_q  <= tcnt_d;
      if (state_q != S_HALT) cyc_q <= cyc_q + 64'd1;
      if (state_q == S_WB) instret_q <= instret_q + 64'd1;
    end
  end

  // Moore outputs: nothing below looks at an ack.
  assign imem_req   = (state_q == S_FETCH);
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && cls.store;
  assign pc_we      = (state_q == S_WB);
  assign rf_wen     = (state_q == S_WB) && (cls.writer || cls.load) && (ir_q[11:7] != 5'd0);
  assign halt       = (state_q == S_HALT);
  assign halt_cause = cause_q;
  assign ir         = ir_q;
  assign cycle_cnt  = cyc_q;
  assign instret    = instret_q;

endmodule

// File: doc/ysyx_220053_seq_ctrl.md
# ysyx_220053_seq_ctrl

Multi-cycle instruction sequencer for the ysyx_220053 RV64 core. It wraps the combinational decoder and datapath and steps each instruction through fetch, decode, execute, optional memory access, and writeback. It performs the valid/ack handshakes with instruction and data memory, raises the register-file and PC write strobes, and halts the core on `ebreak`, illegal opcodes or bus timeout. It also keeps the retired-instruction and cycle counters.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles a memory request may stay unacknowledged before a bus error halt.

Ports:
- `clk`  in  1: single core clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: instruction fetch request. Held high until ack.
- `imem_ack`  in  1: fetch data valid this cycle.
- `imem_rdata`  in  32: fetched instruction word.
- `ir`  out  32: latched instruction, fed to the decoder.
- `dmem_req`  out  1: data request. Held high until ack.
- `dmem_we`  out  1: 1 = store, 0 = load. Valid while `dmem_req` is high.
- `dmem_ack`  in  1: data transfer complete this cycle.
- `pc_we`  out  1: one-cycle PC update strobe.
- `rf_wen`  out  1: one-cycle register-file write strobe.
- `halt`  out  1: sticky; the core is stopped.
- `halt_cause`  out  2: 0 = none, 1 = ebreak, 2 = illegal, 3 = bus timeout.
- `cycle_cnt`  out  64: cycles elapsed since reset, excluding HALT.
- `instret`  out  64: number of retired instructions.

## Operation
- The FSM has six states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: `imem_req`=1. When `imem_ack` is sampled high, `ir` <= `imem_rdata` and the next state is DECODE.
- DECODE: classify by `ir[6:0]`.
  - 0110011, 0010011, 0011011, 0111011, 0110111, 0010111, 1101111, 1100111: writers.
  - 0000011: load. 0100011: store. 1100011: branch, which does not write the register file.
  - 1110011 with `ir`==32'h00100073: ebreak, go to HALT with cause 1.
  - Any other value, including other SYSTEM encodings: go to HALT with cause 2.
  - Otherwise go to EXEC.
- EXEC: one cycle. Loads and stores go to MEM; all other classes go to WB.
- MEM: `dmem_req`=1, and `dmem_we`=1 for stores. On `dmem_ack`, go to WB.
- WB: `pc_we`=1. `rf_wen`=1 for writers and loads when `ir[11:7]`!=0. `instret` increments. The next state is FETCH.
- HALT is absorbing until reset. All strobes and requests are 0; `ir` holds the last value.
- Timeout:
  - A counter of width clog2(TIMEOUT+1) clears on every state entry and counts each FETCH/MEM cycle without ack.
  - When the count reaches TIMEOUT with no ack, go to HALT with cause 3.
  - An ack arriving on the same cycle the count reaches TIMEOUT wins over the timeout.
- Acks sampled while no request is pending are ignored.
- `cycle_cnt` wraps modulo 2^64 and `instret` wraps silently.

## Timing
- Reset values:
  - State = FETCH, so `imem_req`=1 immediately during and after reset.
  - `ir`=32'h00000013 (nop).
  - `dmem_req`, `dmem_we`, `pc_we`, `rf_wen` and `halt` = 0.
  - `halt_cause`, both counters and the timeout counter = 0.
- Requests and strobes are Moore outputs decoded from the state register and `ir`; none depends combinationally on an ack.
- Latency with zero-wait acks (ack high in the first request cycle):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
  - Each wait cycle on an ack adds one cycle.
- `halt` rises in the cycle after the deciding edge, i.e. after DECODE for ebreak/illegal and after the final timeout cycle for cause 3.
- Reset asserted mid-operation, including mid-MEM: all registers clear asynchronously. The pending request is dropped with no handshake completion and no strobe.

## Structure
- Shared package `ysyx_220053_pkg` holds:
  - the state enum (3 bits);
  - the `halt_cause` codes;
  - the opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM, …);
  - `EBREAK` = 32'h00100073.
- Sub-module `ysyx_220053_insn_class`: combinational map from `ir` to {writer, load, store, ebreak, illegal}. It is reused by the difftest hooks.
- The timeout counter and the two 64-bit counters live inline in the sequencer.

## Test plan
- `addi x1,x0,5` (32'h00500093) with ack in the first cycle → `pc_we` and `rf_wen` each high for exactly one cycle, in cycle 4; `instret`=1; FETCH again in cycle 5.
- `ld` (opcode 0000011) with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 consecutive cycles with `dmem_we`=0; WB in cycle 8; `rf_wen`=1.
- `sw` and `beq` → `rf_wen` stays 0 while `pc_we` pulses once; `rd`=0 on `addi x0` also gives `rf_wen`=0.
- 32'h00100073 → `halt`=1 with cause 1 and `cycle_cnt` frozen; 32'hFFFFFFFF → cause 2; further acks have no effect.
- `TIMEOUT`=4 with `imem_ack` never asserted → halt with cause 3 after 4 request cycles; repeat with ack on the 4th cycle → no halt.
- `rst_n` pulsed low during MEM wait → `dmem_req`=0 immediately; after release `imem_req`=1, counters 0, `ir`=32'h00000013.
